// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - 2-flop sync, debounce FSM and rise/fall strobes per channel
// Optional auto-repeat of rise strobes is built when BTN_REPEAT_EN is defined.
module input_conditioner #(
  parameter int N_CH            = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter logic [N_CH-1:0] REPEAT_MASK = 8'h0F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_rise
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] sync_a;
  logic [N_CH-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      s      <= '0;
    end else begin
      sync_a <= raw_in;
      s      <= sync_a;
    end
  end

  assign any_rise = |rise;

`ifndef BTN_REPEAT_EN
  logic unused_mask;
  assign unused_mask = ^REPEAT_MASK;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             lvl_q;
    logic             rise_q;
    logic             fall_q;
    logic             rep_fire;

    assign level[i] = lvl_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;

`ifdef BTN_REPEAT_EN
    localparam bit REP_ON = REPEAT_MASK[i];
    logic [CNT_W-1:0] tmr;
    logic             repeating;
    logic [CNT_W-1:0] tmr_limit;

    // First repeat waits REPEAT_DELAY from accept, later ones REPEAT_PERIOD apart.
    assign tmr_limit = repeating ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
    assign rep_fire  = REP_ON && (state == ST_HELD || state == ST_RELEASE_WAIT)
                       && (tmr == tmr_limit);

    always_ff @(posedge clk) begin
      if (rst) begin
        tmr       <= '0;
        repeating <= 1'b0;
      end else if (state == ST_PRESS_WAIT && s[i] && cnt == DB_LAST) begin
        tmr       <= '0;
        repeating <= 1'b0;
      end else if (REP_ON && (state == ST_HELD || state == ST_RELEASE_WAIT)) begin
        if (rep_fire) begin
          tmr       <= '0;
          repeating <= 1'b1;
        end else begin
          tmr <= tmr + 1'b1;
        end
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (s[i]) begin
              state <= ST_PRESS_WAIT;
              cnt   <= CNT_W'(1);
            end
          end
          ST_PRESS_WAIT: begin
            if (!s[i]) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state  <= ST_HELD;
              cnt    <= '0;
              lvl_q  <= 1'b1;
              rise_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_HELD: begin
            if (!s[i]) begin
              state <= ST_RELEASE_WAIT;
              cnt   <= CNT_W'(1);
            end
            if (rep_fire) rise_q <= 1'b1;
          end
          default: begin
            // A repeat strobe is dropped only when the release is accepted this cycle.
            if (s[i]) begin
              state <= ST_HELD;
              cnt   <= '0;
              if (rep_fire) rise_q <= 1'b1;
            end else if (cnt == DB_LAST) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              lvl_q  <= 1'b0;
              fall_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
              if (rep_fire) rise_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed bench for input_conditioner with debounce 4, repeat 10/3
module tb_input_conditioner;

  logic       clk;
  logic       rst;
  logic [7:0] raw;
  logic [7:0] level;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       any_rise;

  int total;
  int bad;

  input_conditioner #(
    .N_CH(8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3),
    .REPEAT_MASK(8'h0F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_in(raw),
    .level(level),
    .rise(rise),
    .fall(fall),
    .any_rise(any_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    raw   = 8'h00;
    rst   = 1'b1;

    // 1. reset
    tick();
    tick();
    check("rst_level", 32'(level), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);
    check("rst_any", 32'(any_rise), 32'h0);
    rst = 1'b0;
    tick();
    tick();

    // 2. clean press and release on channel 0
    raw[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check($sformatf("press0_rise_t%0d", t), 32'(rise[0]), 32'(t == 6));
      check($sformatf("press0_level_t%0d", t), 32'(level[0]), 32'(t >= 6));
    end
    raw[0] = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check($sformatf("rel0_fall_t%0d", t), 32'(fall[0]), 32'(t == 6));
      check($sformatf("rel0_level_t%0d", t), 32'(level[0]), 32'(t < 6));
      check($sformatf("rel0_rise_t%0d", t), 32'(rise[0]), 32'h0);
    end
    tick();

    // 3. short glitch on channel 1
    raw[1] = 1'b1;
    tick();
    tick();
    tick();
    raw[1] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check($sformatf("glitch1_rise_t%0d", t), 32'(rise[1]), 32'h0);
      check($sformatf("glitch1_level_t%0d", t), 32'(level[1]), 32'h0);
    end

    // 4. bouncy press on channel 2: 1,0,1,1,0,1 then steady
    raw[2] = 1'b1; tick(); check("bounce2_a", 32'(rise[2]), 32'h0);
    raw[2] = 1'b0; tick(); check("bounce2_b", 32'(rise[2]), 32'h0);
    raw[2] = 1'b1; tick(); check("bounce2_c", 32'(rise[2]), 32'h0);
    raw[2] = 1'b1; tick(); check("bounce2_d", 32'(rise[2]), 32'h0);
    raw[2] = 1'b0; tick(); check("bounce2_e", 32'(rise[2]), 32'h0);
    raw[2] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check($sformatf("bounce2_rise_t%0d", t), 32'(rise[2]), 32'(t == 6));
      check($sformatf("bounce2_level_t%0d", t), 32'(level[2]), 32'(t >= 6));
    end
    raw[2] = 1'b0;
    for (int t = 1; t <= 8; t++) tick();
    check("bounce2_level_off", 32'(level[2]), 32'h0);

    // 5. simultaneous rise on channels 3 and 5
    raw[3] = 1'b1;
    raw[5] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check($sformatf("sim_rise_t%0d", t), 32'(rise), (t == 6) ? 32'h28 : 32'h0);
      check($sformatf("sim_any_t%0d", t), 32'(any_rise), 32'(t == 6));
    end
    raw[3] = 1'b0;
    raw[5] = 1'b0;
    for (int t = 1; t <= 8; t++) tick();
    check("sim_level_off", 32'(level), 32'h0);

    // 6. long hold on channel 0 (repeat-enabled) and channel 5 (masked)
    raw[0] = 1'b1;
    raw[5] = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      logic exp_r0;
      tick();
`ifdef BTN_REPEAT_EN
      exp_r0 = (t == 6) || (t >= 16 && t <= 34 && ((t - 16) % 3) == 0);
`else
      exp_r0 = (t == 6);
`endif
      check($sformatf("hold0_rise_t%0d", t), 32'(rise[0]), 32'(exp_r0));
      check($sformatf("hold0_fall_t%0d", t), 32'(fall[0]), 32'(t == 36));
      check($sformatf("hold0_level_t%0d", t), 32'(level[0]), 32'(t >= 6 && t < 36));
      check($sformatf("hold5_rise_t%0d", t), 32'(rise[5]), 32'(t == 6));
      if (t == 30) begin
        raw[0] = 1'b0;
        raw[5] = 1'b0;
      end
    end
    tick();
    check("hold_level_off", 32'(level), 32'h0);

    // 7. reset in the middle of a debounce on channel 6
    raw[6] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("rstmid_pre_rise", 32'(rise[6]), 32'h0);
    rst = 1'b1;
    tick();
    check("rstmid_level", 32'(level[6]), 32'h0);
    check("rstmid_rise", 32'(rise[6]), 32'h0);
    rst = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check($sformatf("rstmid_rise_t%0d", t), 32'(rise[6]), 32'(t == 6));
      check($sformatf("rstmid_level_t%0d", t), 32'(level[6]), 32'(t >= 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
